// File: rtl/reg_wb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// reg_wb_scheduler_pkg
// Shared sizing for the register write-back scheduler and the register cells.
// Requester order is fixed: 0 = ALU, 1 = LSU, 2 = MUL.
// -----------------------------------------------------------------------------
package reg_wb_scheduler_pkg;

  localparam int W_OPR  = 32;              // operand / write-back data width
  localparam int N_REG  = 32;              // architectural registers
  localparam int W_RIDX = $clog2(N_REG);   // register index width (5)
  localparam int N_REQ  = 3;               // write-back requesters
  localparam int W_RPTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [W_RPTR-1:0] {
    REQ_ALU = W_RPTR'(0),
    REQ_LSU = W_RPTR'(1),
    REQ_MUL = W_RPTR'(2)
  } req_id_e;

  typedef logic [W_RIDX-1:0] ridx_t;
  typedef logic [N_REG-1:0]  rvec_t;
  typedef logic [W_OPR-1:0]  opr_t;

  // Registered write-back stage: one entry, valid only for a real register.
  typedef struct packed {
    logic  vld;
    ridx_t rd;
    opr_t  data;
  } wb_stage_t;

  // One-hot strobe for a register index.
  function automatic rvec_t ridx_onehot(input ridx_t idx);
    rvec_t one;
    one = {{(N_REG-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/reg_wb_scheduler_if.sv
// -----------------------------------------------------------------------------
// reg_wb_scheduler_if
// Bundles the requester handshake, the write-back bus to the register cells and
// the issue-side reservation signals.
//   slave  : scheduler side (takes requests/reservations, drives strobes)
//   master : environment side (requesters, issue stage, register cells)
// Signal suffixes are named from the scheduler's point of view.
// -----------------------------------------------------------------------------
interface reg_wb_scheduler_if;
  import reg_wb_scheduler_pkg::*;

  // requesters
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*W_RIDX-1:0] req_rd_i;
  logic [N_REQ*W_OPR-1:0]  req_data_i;
  logic [N_REQ-1:0]        req_ready_o;

  // write-back to cells
  logic [N_REG-1:0]        wb_o;
  logic [W_OPR-1:0]        wb_data_o;

  // issue-stage reservation
  logic                    rsv_valid_i;
  logic [W_RIDX-1:0]       rsv_rd_i;
  logic [W_RIDX-1:0]       src1_i;
  logic [W_RIDX-1:0]       src2_i;
  logic [N_REG-1:0]        res_bits_i;
  logic [N_REG-1:0]        w_reserve_o;
  logic                    stall_o;

  modport slave (
    input  req_valid_i, req_rd_i, req_data_i,
    output req_ready_o,
    output wb_o, wb_data_o,
    input  rsv_valid_i, rsv_rd_i, src1_i, src2_i, res_bits_i,
    output w_reserve_o, stall_o
  );

  modport master (
    output req_valid_i, req_rd_i, req_data_i,
    input  req_ready_o,
    input  wb_o, wb_data_o,
    output rsv_valid_i, rsv_rd_i, src1_i, src2_i, res_bits_i,
    input  w_reserve_o, stall_o
  );

endinterface

// File: rtl/reg_wb_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// N-wide round-robin arbiter. The search starts at the pointer and wraps; at
// most one grant per cycle. After a grant to k the pointer moves to k+1 (mod
// N); with no grant it holds.
// Ports:
//   clk        clock
//   rst        async reset, active-low; grants are forced to 0 while low
//   req_i      request vector
//   gnt_o      one-hot grant (combinational)
//   gnt_idx_o  index of the granted requester
//   gnt_vld_o  a grant is being issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int W_PTR = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [W_PTR-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [W_PTR-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_raw;
  logic [W_PTR-1:0] idx_raw;
  logic             found;
  int               cand;

  always_comb begin
    gnt_raw = '0;
    idx_raw = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_raw[cand] = 1'b1;
        idx_raw      = W_PTR'(cand);
      end
    end
  end

  // Ready must read 0 during reset even though requests are still observed.
  assign gnt_o     = rst ? gnt_raw : '0;
  assign gnt_vld_o = rst & found;
  assign gnt_idx_o = idx_raw;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o) begin
      ptr_d = (idx_raw == W_PTR'(N-1)) ? '0 : idx_raw + W_PTR'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// -----------------------------------------------------------------------------
// reg_wb_scheduler
// Schedules register-file write-backs from three requesters (ALU, LSU, MUL)
// and screens issue-stage destination reservations for hazards.
// Ports:
//   clk  clock, all state on posedge
//   rst  async reset, active-low
//   bus  reg_wb_scheduler_if.slave
//        req_valid_i/req_rd_i/req_data_i -> req_ready_o (one-hot grant)
//        wb_o/wb_data_o  registered one-hot write strobe + shared data
//        rsv_valid_i/rsv_rd_i/src1_i/src2_i/res_bits_i
//                        -> w_reserve_o (one-hot), stall_o
// Write-back has one cycle of latency through a single pipeline register; that
// register is the only path to the cells, so a reservation check always sees
// the cell state before the same-cycle write-back lands.
// -----------------------------------------------------------------------------
module reg_wb_scheduler
  import reg_wb_scheduler_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  reg_wb_scheduler_if.slave bus
);

  // ---------------------------------------------------------------- arbitration
  logic [N_REQ-1:0]  gnt;
  logic [W_RPTR-1:0] gnt_idx;
  logic              gnt_vld;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req_valid_i),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign bus.req_ready_o = gnt;

  ridx_t sel_rd;
  opr_t  sel_data;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == W_RPTR'(k)) begin
        sel_rd   = bus.req_rd_i[k*W_RIDX +: W_RIDX];
        sel_data = bus.req_data_i[k*W_OPR +: W_OPR];
      end
    end
  end

  // ---------------------------------------------------------- write-back stage
  wb_stage_t wb_q, wb_d;

  // A grant to r0 is still consumed, but never becomes a valid write.
  always_comb begin
    wb_d     = wb_q;
    wb_d.vld = 1'b0;
    if (gnt_vld) begin
      wb_d.vld  = (sel_rd != '0);
      wb_d.rd   = sel_rd;
      wb_d.data = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  assign bus.wb_o      = wb_q.vld ? ridx_onehot(wb_q.rd) : '0;
  assign bus.wb_data_o = wb_q.data;

  // ------------------------------------------------------ reservation / hazard
  logic haz_src1, haz_src2, haz_waw;

  assign haz_src1 = (bus.src1_i   != '0) && bus.res_bits_i[bus.src1_i];
  assign haz_src2 = (bus.src2_i   != '0) && bus.res_bits_i[bus.src2_i];
  assign haz_waw  = (bus.rsv_rd_i != '0) && bus.res_bits_i[bus.rsv_rd_i];

  assign bus.stall_o = bus.rsv_valid_i && (haz_src1 || haz_src2 || haz_waw);

  // Overlap with a same-cycle wb_o to the same register is resolved in the
  // cell, which gives the reserve strobe priority.
  assign bus.w_reserve_o = (bus.rsv_valid_i && !bus.stall_o && (bus.rsv_rd_i != '0))
                           ? ridx_onehot(bus.rsv_rd_i) : '0;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_scheduler
// Directed bench for reg_wb_scheduler. Expected write-backs are queued when a
// grant is driven and popped one cycle later when wb_o is sampled. A small
// register-cell model (reserve wins over write-back) tracks reservation bits.
// -----------------------------------------------------------------------------
module tb_reg_wb_scheduler;
  import reg_wb_scheduler_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_wb_scheduler_if ifc ();

  reg_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  logic [N_REQ-1:0]  valid;
  logic [W_RIDX-1:0] rd_v   [N_REQ];
  logic [W_OPR-1:0]  data_v [N_REQ];

  assign ifc.req_valid_i = valid;
  assign ifc.req_rd_i    = {rd_v[2], rd_v[1], rd_v[0]};
  assign ifc.req_data_i  = {data_v[2], data_v[1], data_v[0]};

  logic              rsv_valid;
  logic [W_RIDX-1:0] rsv_rd, src1, src2;
  logic [N_REG-1:0]  res_bits;

  assign ifc.rsv_valid_i = rsv_valid;
  assign ifc.rsv_rd_i    = rsv_rd;
  assign ifc.src1_i      = src1;
  assign ifc.src2_i      = src2;
  assign ifc.res_bits_i  = res_bits;

  // register-cell reservation model
  logic [N_REG-1:0] cell_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) cell_q <= '0;
    else      cell_q <= (cell_q & ~ifc.wb_o) | ifc.w_reserve_o;
  end

  typedef struct {
    logic [N_REG-1:0] wb;
    logic [W_OPR-1:0] data;
    bit               chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives valid, checks the grant, queues the expected
  // write-back, then checks wb_o after the next posedge. Returns at a negedge.
  task automatic do_cycle(input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] exp_gnt,
                          input string tag);
    exp_t e, got;
    valid = v;
    #1;
    chk({tag, ".ready"}, 32'(ifc.req_ready_o), 32'(exp_gnt));
    e.wb = '0; e.data = '0; e.chk_data = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (exp_gnt[k] && rd_v[k] != '0) begin
        e.wb       = ridx_onehot(rd_v[k]);
        e.data     = data_v[k];
        e.chk_data = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk({tag, ".wb"}, ifc.wb_o, got.wb);
      if (got.chk_data) chk({tag, ".wb_data"}, ifc.wb_data_o, got.data);
    end
    @(negedge clk);
  endtask

  task automatic hz(input logic rv, input logic [W_RIDX-1:0] s1, input logic [W_RIDX-1:0] s2,
                    input logic [W_RIDX-1:0] rd, input logic [N_REG-1:0] rb,
                    input logic exp_stall, input logic [N_REG-1:0] exp_res, input string tag);
    rsv_valid = rv; src1 = s1; src2 = s2; rsv_rd = rd; res_bits = rb;
    #1;
    chk({tag, ".stall"}, 32'(ifc.stall_o), 32'(exp_stall));
    chk({tag, ".w_reserve"}, ifc.w_reserve_o, exp_res);
  endtask

  initial begin
    rst = 1'b0;
    valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rd_v[k] = '0;
      data_v[k] = '0;
    end
    rsv_valid = 1'b0; rsv_rd = '0; src1 = '0; src2 = '0; res_bits = '0;

    // reset: ready forced low, pipeline cleared, hazard logic still live
    @(negedge clk);
    valid = 3'b111;
    #1;
    chk("rst.ready", 32'(ifc.req_ready_o), 32'd0);
    chk("rst.wb", ifc.wb_o, 32'd0);
    chk("rst.wb_data", ifc.wb_data_o, 32'd0);
    hz(1'b1, 5'd5, 5'd0, 5'd9, 32'h0000_0020, 1'b1, 32'd0, "rst.haz");
    hz(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, "rst.idle");
    @(negedge clk);
    rst = 1'b1;

    // fairness from reset
    rd_v[0] = 5'd1; data_v[0] = 32'h1000_0001;
    rd_v[1] = 5'd2; data_v[1] = 32'h2000_0002;
    rd_v[2] = 5'd3; data_v[2] = 32'h3000_0003;
    do_cycle(3'b111, 3'b001, "fair0");
    do_cycle(3'b111, 3'b010, "fair1");
    do_cycle(3'b111, 3'b100, "fair2");
    do_cycle(3'b111, 3'b001, "fair3");
    do_cycle(3'b111, 3'b010, "fair4");
    do_cycle(3'b111, 3'b100, "fair5");
    do_cycle(3'b000, 3'b000, "fair_idle");

    // single write-back, one-cycle pulse
    rd_v[0] = 5'd7; data_v[0] = 32'hDEAD_BEEF;
    do_cycle(3'b001, 3'b001, "single");
    do_cycle(3'b000, 3'b000, "single_idle1");
    do_cycle(3'b000, 3'b000, "single_idle2");

    // r0 write consumed but suppressed
    rd_v[1] = 5'd0; data_v[1] = 32'h0BAD_0000;
    do_cycle(3'b010, 3'b010, "r0");
    do_cycle(3'b000, 3'b000, "r0_idle");

    // duplicate rd serialized by arbitration order (pointer at 2)
    rd_v[0] = 5'd9; data_v[0] = 32'hAAAA_0009;
    rd_v[2] = 5'd9; data_v[2] = 32'hCCCC_0009;
    do_cycle(3'b101, 3'b100, "dup_a");
    do_cycle(3'b001, 3'b001, "dup_b");
    // pointer at 1, only requester 2 valid
    rd_v[2] = 5'd31; data_v[2] = 32'h3131_3131;
    do_cycle(3'b100, 3'b100, "skip");
    do_cycle(3'b000, 3'b000, "skip_idle");

    // hazard screening
    hz(1'b1, 5'd5, 5'd0, 5'd9, 32'h0000_0020, 1'b1, 32'd0,        "haz_src1");
    hz(1'b1, 5'd6, 5'd0, 5'd9, 32'h0000_0020, 1'b0, 32'h0000_0200, "no_haz");
    hz(1'b1, 5'd1, 5'd6, 5'd9, 32'h0000_0040, 1'b1, 32'd0,        "haz_src2");
    hz(1'b1, 5'd1, 5'd2, 5'd9, 32'h0000_0200, 1'b1, 32'd0,        "haz_waw");
    hz(1'b1, 5'd0, 5'd0, 5'd0, 32'h0000_0001, 1'b0, 32'd0,        "haz_r0");
    hz(1'b0, 5'd5, 5'd5, 5'd5, 32'h0000_0020, 1'b0, 32'd0,        "haz_norsv");
    hz(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0,                "haz_clear");

    // same-cycle reserve and write-back to r4 (pointer at 0)
    rd_v[0] = 5'd4; data_v[0] = 32'h4444_0004;
    do_cycle(3'b001, 3'b001, "r4_wb");
    rsv_valid = 1'b1; rsv_rd = 5'd4; src1 = '0; src2 = '0; res_bits = '0;
    #1;
    chk("r4.wb", ifc.wb_o, 32'h0000_0010);
    chk("r4.w_reserve", ifc.w_reserve_o, 32'h0000_0010);
    @(posedge clk);
    #1;
    chk("r4.cell_res", 32'(cell_q[4]), 32'd1);
    rsv_valid = 1'b0; rsv_rd = '0;
    @(negedge clk);

    // reset with a grant in flight (pointer at 1)
    rd_v[1] = 5'd3; data_v[1] = 32'h3333_0003;
    valid = 3'b010;
    #1;
    chk("mid.ready", 32'(ifc.req_ready_o), 32'b010);
    #2;
    rst = 1'b0;
    #1;
    chk("mid.ready_rst", 32'(ifc.req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("mid.wb0", ifc.wb_o, 32'd0);
    chk("mid.wb_data0", ifc.wb_data_o, 32'd0);
    @(negedge clk);
    valid = 3'b111;
    @(posedge clk);
    #1;
    chk("mid.wb1", ifc.wb_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_cycle(3'b111, 3'b001, "post_rst");
    do_cycle(3'b000, 3'b000, "post_rst_idle");

    chk("sb.drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
